// File: rtl/nx_stat_counter_pkg.sv
// Shared types for the statistics-counter storage block.
//
// Contents:
//   mem_state_e : storage-side state machine (INIT while the array is
//                 being prepared after reset, IDLE once traffic is allowed).
package nx_stat_counter;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } mem_state_e;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for a power-of-two circular buffer. The data
// storage lives in the instantiating module; this block only tracks where to
// write, where to read and how many entries are held.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push     : store one entry this cycle (caller never pushes when full)
//   pop      : drop the head entry this cycle (caller never pops when empty)
//   wr_ptr   : slot the next push lands in
//   rd_ptr   : slot holding the current head
//   count    : number of entries held, 0..DEPTH
//   empty    : count == 0
module fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [PW:0]   count,
    output logic          empty
);

    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic [PW:0]   count_d,  count_q;

    // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign empty  = (count_q == (PW+1)'(0));

endmodule

// File: rtl/nx_stat_counter_mem.sv
// Counter storage responder for nx_stat_counter_ctrl. Holds N_ENTRIES words
// of TOTAL_WIDTH bits in a single-port array and serves one read (ar/r) or
// one write (aw/b) per cycle; writes win when both are offered.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   ar_valid/ar_ready/ar_addr   : read-address channel
//   r_valid/r_ready/r_data      : read-data channel, in ar acceptance order
//   aw_valid/aw_ready/aw_addr/aw_data : write channel
//   b_valid/b_ready             : write-response channel (up to B_MAX owed)
//   init_done                   : high once the array accepts traffic
//
// Build option NX_STAT_COUNTER_MEM_INIT_CLEAR_EN: when defined, the INIT state
// walks the array writing zeros (N_ENTRIES cycles); otherwise INIT lasts one
// cycle and the array contents are undefined until written. Array contents
// survive rst either way (apart from the clear sweep itself).
module nx_stat_counter_mem
    import nx_stat_counter::*;
#(
    parameter int N_ENTRIES    = 1024,
    parameter int TOTAL_WIDTH  = 70,
    parameter int R_FIFO_DEPTH = 4,
    parameter int B_MAX        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [$clog2(N_ENTRIES)-1:0] ar_addr,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [TOTAL_WIDTH-1:0]       r_data,
    input  logic                         aw_valid,
    output logic                         aw_ready,
    input  logic [$clog2(N_ENTRIES)-1:0] aw_addr,
    input  logic [TOTAL_WIDTH-1:0]       aw_data,
    output logic                         b_valid,
    input  logic                         b_ready,
    output logic                         init_done
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int PW = $clog2(R_FIFO_DEPTH);
    localparam int BW = $clog2(B_MAX + 1);
    localparam logic [PW:0]   FIFO_LIM = (PW+1)'(R_FIFO_DEPTH);
    localparam logic [BW-1:0] B_LIM    = BW'(B_MAX);

    mem_state_e state_q;
    logic       init_done_q;
`ifdef NX_STAT_COUNTER_MEM_INIT_CLEAR_EN
    logic [AW-1:0] init_idx_q;
`endif

    logic [TOTAL_WIDTH-1:0] mem_q   [N_ENTRIES];
    logic [TOTAL_WIDTH-1:0] r_buf_q [R_FIFO_DEPTH];

    logic                   rd_vld_d,  rd_vld_q;
    logic [TOTAL_WIDTH-1:0] rd_data_d, rd_data_q;
    logic [BW-1:0]          b_cnt_d,   b_cnt_q;

    logic ar_ok_s, aw_ok_s;
    logic ar_ready_s, aw_ready_s, r_valid_s, b_valid_s;
    logic ar_hs_s, aw_hs_s, r_hs_s, b_hs_s;
    logic [PW:0] occ_s;

    logic                   mem_we_s;
    logic [AW-1:0]          mem_wa_s;
    logic [TOTAL_WIDTH-1:0] mem_wd_s;

    logic [PW-1:0] fifo_wr_ptr_s, fifo_rd_ptr_s;
    logic [PW:0]   fifo_count_s;
    logic          fifo_empty_s;

    // Out-of-range addresses only exist when N_ENTRIES is not a power of two.
    generate
        if (N_ENTRIES == (1 << AW)) begin : g_addr_full
            assign ar_ok_s = 1'b1;
            assign aw_ok_s = 1'b1;
        end else begin : g_addr_chk
            localparam logic [AW:0] ADDR_LIM = (AW+1)'(N_ENTRIES);
            assign ar_ok_s = ({1'b0, ar_addr} < ADDR_LIM);
            assign aw_ok_s = ({1'b0, aw_addr} < ADDR_LIM);
        end
    endgenerate

    fifo_ctrl #(
        .DEPTH (R_FIFO_DEPTH)
    ) u_r_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (rd_vld_q),
        .pop    (r_hs_s),
        .wr_ptr (fifo_wr_ptr_s),
        .rd_ptr (fifo_rd_ptr_s),
        .count  (fifo_count_s),
        .empty  (fifo_empty_s)
    );

    // Channel readiness and handshakes. A read still in the pipeline register
    // counts against FIFO space so the push one cycle later always fits.
    always_comb begin
        b_valid_s  = (b_cnt_q != BW'(0));
        r_valid_s  = !fifo_empty_s;
        b_hs_s     = b_valid_s && b_ready;
        r_hs_s     = r_valid_s && r_ready;
        aw_ready_s = init_done_q && ((b_cnt_q < B_LIM) || b_hs_s);
        aw_hs_s    = aw_valid && aw_ready_s;
        occ_s      = fifo_count_s + (PW+1)'(rd_vld_q);
        ar_ready_s = init_done_q && !aw_hs_s && (occ_s < FIFO_LIM);
        ar_hs_s    = ar_valid && ar_ready_s;
    end

    // Read pipeline and outstanding write-response count.
    always_comb begin
        rd_vld_d = ar_hs_s;
        if (ar_hs_s) begin
            rd_data_d = ar_ok_s ? mem_q[ar_addr] : '0;
        end else begin
            rd_data_d = rd_data_q;
        end
        case ({aw_hs_s, b_hs_s})
            2'b10:   b_cnt_d = b_cnt_q + BW'(1);
            2'b01:   b_cnt_d = b_cnt_q - BW'(1);
            default: b_cnt_d = b_cnt_q;
        endcase
    end

    // Array write port: clear sweep during INIT, otherwise accepted writes.
    always_comb begin
`ifdef NX_STAT_COUNTER_MEM_INIT_CLEAR_EN
        if (state_q == INIT) begin
            mem_we_s = !rst;
            mem_wa_s = init_idx_q;
            mem_wd_s = '0;
        end else begin
            mem_we_s = aw_hs_s && aw_ok_s;
            mem_wa_s = aw_addr;
            mem_wd_s = aw_data;
        end
`else
        mem_we_s = aw_hs_s && aw_ok_s;
        mem_wa_s = aw_addr;
        mem_wd_s = aw_data;
`endif
    end

    // Init/idle state machine; init_done is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_done_q <= 1'b0;
`ifdef NX_STAT_COUNTER_MEM_INIT_CLEAR_EN
            init_idx_q  <= '0;
`endif
        end else begin
            case (state_q)
                INIT: begin
`ifdef NX_STAT_COUNTER_MEM_INIT_CLEAR_EN
                    if (init_idx_q == AW'(N_ENTRIES - 1)) begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        init_idx_q  <= init_idx_q + AW'(1);
                    end
`else
                    state_q     <= IDLE;
                    init_done_q <= 1'b1;
`endif
                end
                IDLE: begin
                    state_q     <= IDLE;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= INIT;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath control registers; all pending responses are dropped on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            b_cnt_q   <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            b_cnt_q   <= b_cnt_d;
        end
    end

    // Counter array; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
    end

    // Read-response storage; slot validity is tracked by u_r_fifo.
    always_ff @(posedge clk) begin
        if (rd_vld_q) begin
            r_buf_q[fifo_wr_ptr_s] <= rd_data_q;
        end
    end

    assign ar_ready  = ar_ready_s;
    assign aw_ready  = aw_ready_s;
    assign r_valid   = r_valid_s;
    assign r_data    = r_buf_q[fifo_rd_ptr_s];
    assign b_valid   = b_valid_s;
    assign init_done = init_done_q;

endmodule

// File: doc/nx_stat_counter_mem.md
NX_STAT_COUNTER_MEM -- requirements
Module: nx_stat_counter_mem

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 1024: number of counter entries stored.
REQ-002 SHALL have parameter TOTAL_WIDTH, default 70: bits per entry.
REQ-003 SHALL have parameter R_FIFO_DEPTH, default 4: read-response buffer depth, power of 2.
REQ-004 SHALL have parameter B_MAX, default 4: maximum unacknowledged write responses.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-007 SHALL have ports ar_valid in 1, ar_ready out 1, ar_addr in log2(N_ENTRIES): read-address channel.
REQ-008 SHALL have ports r_valid out 1, r_ready in 1, r_data out TOTAL_WIDTH: read-data channel.
REQ-009 SHALL have ports aw_valid in 1, aw_ready out 1, aw_addr in log2(N_ENTRIES), aw_data in TOTAL_WIDTH: write channel.
REQ-010 SHALL have ports b_valid out 1, b_ready in 1: write-response channel.
REQ-011 SHALL have port init_done, output, 1: storage ready for traffic.

Function
REQ-012 SHALL be the responder to nx_stat_counter_ctrl's ar/r/aw/b initiator ports; a transfer occurs on valid&&ready in the same cycle.
REQ-013 SHALL hold storage as a single-port array of N_ENTRIES x TOTAL_WIDTH; one access (read or write) per cycle.
REQ-014 SHALL give aw priority: ar_ready SHALL be 0 in any cycle aw_valid&&aw_ready is 1.
REQ-015 SHALL write aw_data to aw_addr in the aw handshake cycle; a read accepted in any later cycle returns the new value.
REQ-016 SHALL read the array in the ar handshake cycle and push the data into the r FIFO exactly 1 cycle later; r_valid earliest 1 cycle after ar handshake.
REQ-017 SHALL return r_data in ar acceptance order; r_valid = FIFO not empty; r_data = FIFO head; pop on r_valid&&r_ready.
REQ-018 SHALL assert ar_ready only when init_done && (FIFO used + reads in flight) < R_FIFO_DEPTH; the FIFO never overflows.
REQ-019 SHALL keep a b counter 0..B_MAX: +1 on aw handshake, -1 on b handshake, unchanged on both; b_valid = (count != 0).
REQ-020 SHALL assert aw_ready only when init_done && (count < B_MAX || b_valid&&b_ready).
REQ-021 SHALL hold r_data stable while r_valid && !r_ready; SHALL not drop r_valid without a handshake.
REQ-022 SHALL treat ar_addr/aw_addr >= N_ENTRIES as error: write ignored, read returns 0, b/r still produced.
REQ-023 SHALL implement FSM INIT -> IDLE; IDLE is the only state accepting traffic; init_done = (state == IDLE).

Reset
REQ-024 SHALL on rst: state INIT, FIFO empty, in-flight cleared, b count 0, r_valid 0, b_valid 0, ar_ready 0, aw_ready 0, init_done 0.
REQ-025 SHALL on rst mid-operation discard all pending r data and b responses; array contents are retained unless REQ-027 applies.

Configuration
REQ-026 SHALL use macro NX_STAT_COUNTER_MEM_INIT_CLEAR_EN.
REQ-027 With macro defined: INIT SHALL write 0 to entries 0..N_ENTRIES-1, one per cycle, then go IDLE; init_done rises N_ENTRIES cycles after rst deasserts.
REQ-028 Without macro: INIT SHALL last exactly 1 cycle after rst deasserts, no array writes; contents undefined until written.

Structure
REQ-029 SHALL place state enum mem_state_e {INIT, IDLE} in package nx_stat_counter.
REQ-030 SHALL instantiate existing fifo_ctrl (DEPTH=R_FIFO_DEPTH) for the r FIFO pointers; data storage local.

Verification
REQ-031 Init (macro on, N_ENTRIES=16): release rst -> init_done at cycle 16; ar addr 5 -> r_data 0.
REQ-032 Write-then-read: aw addr 3 data 0x2A, then ar addr 3 next cycle -> b_valid cycle+1, r_data 0x2A.
REQ-033 Simultaneous aw addr 7 data 0x11 and ar addr 7 -> aw accepted, ar stalled 1 cycle, r_data 0x11.
REQ-034 r_ready held 0, 6 ar issued (depth 4) -> exactly 4 accepted, ar_ready 0, r order addr0..3 on release.
REQ-035 b_ready held 0, 5 aw issued (B_MAX 4) -> 4 accepted; release b_ready -> 4 b handshakes, 5th aw accepted same cycle as first b.
REQ-036 rst asserted with 2 r pending and b count 3 -> r_valid/b_valid 0 next cycle, no stale responses after init_done.
